// File: rtl/blob_arb_pkg.sv
// blob_arb_pkg: shared state type and width helper for the blob round-robin arbiter
package blob_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder starting one past ptr
module rr_pick #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);
  assign any = |req;
  // scan from the farthest candidate back so the nearest one after ptr wins
  always_comb begin
    idx = '0;
    for (int i = N; i >= 1; i--)
      if (req[IW'((int'(ptr) + i) % N)]) idx = IW'((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/blob_rr_arbiter.sv
// blob_rr_arbiter: round-robin, blob-locked arbiter with a per-blob beat ceiling
module blob_rr_arbiter
  import blob_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH = 512,
  parameter int MAX_BEATS = 320,
  localparam int IW = clog2(NUM_PORTS),
  localparam int CW = clog2(MAX_BEATS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS*WIDTH-1:0] req_din,
  input  logic [NUM_PORTS-1:0]       req_din_en,
  input  logic [NUM_PORTS-1:0]       req_din_eop,
  output logic [NUM_PORTS-1:0]       req_din_rdy,
  output logic [WIDTH-1:0]           blob_dout,
  input  logic                       blob_dout_rdy,
  output logic                       blob_dout_en,
  output logic                       blob_dout_eop,
  output logic [IW-1:0]              grant_id,
  output logic                       busy,
  output logic [NUM_PORTS-1:0]       trunc_err
);
  state_t state;
  logic [IW-1:0] rr_ptr, pick;
  logic [CW-1:0] beat_cnt;
  logic [NUM_PORTS-1:0] sel;
  logic any, en_g, eop_g, at_max, xfer;
  rr_pick #(.N(NUM_PORTS), .IW(IW)) u_pick (
    .req(req_din_en),
    .ptr(rr_ptr),
    .any(any),
    .idx(pick)
  );
  assign sel = NUM_PORTS'(1) << grant_id;
  assign en_g = req_din_en[grant_id];
  assign eop_g = req_din_eop[grant_id];
  assign at_max = beat_cnt == CW'(MAX_BEATS - 1);
  assign xfer = state == GRANT && en_g && blob_dout_rdy;
  assign blob_dout_en = xfer;
  assign blob_dout_eop = xfer && (eop_g || at_max);
  assign blob_dout = state == GRANT ? req_din[grant_id*WIDTH +: WIDTH] : '0;
  assign req_din_rdy = state == GRANT ? (blob_dout_rdy ? sel : '0) : state == DRAIN ? sel : '0;
  assign busy = state != IDLE;
  // arbitration FSM: pick in IDLE, pass through in GRANT, discard the overlong tail in DRAIN
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= IW'(NUM_PORTS - 1);
      grant_id <= '0;
      beat_cnt <= '0;
      trunc_err <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          grant_id <= pick;
          rr_ptr <= pick;
          state <= GRANT;
        end
        GRANT: if (xfer) begin
          beat_cnt <= (eop_g || at_max) ? '0 : beat_cnt + 1'b1;
          if (eop_g) state <= IDLE;
          else if (at_max) begin
            state <= DRAIN;
            trunc_err[grant_id] <= 1'b1;
          end
        end
        DRAIN: if (en_g && eop_g) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blob_rr_arbiter.sv
// tb_blob_rr_arbiter: directed self-checking bench for blob_rr_arbiter
module tb_blob_rr_arbiter;
  localparam int N = 4, W = 16, MB = 4;
  logic clk = 0, rst = 1;
  logic [N*W-1:0] req_din = '1;
  logic [N-1:0] req_din_en = '0, req_din_eop = '0, req_din_rdy, trunc_err;
  logic [W-1:0] blob_dout;
  logic blob_dout_rdy = 1, blob_dout_en, blob_dout_eop, busy;
  logic [1:0] grant_id;
  int checks = 0, failures = 0;
  int bc[N], blk[N];
  int ph, b, ep, bt;
  logic r;
  always #5 clk = ~clk;
  blob_rr_arbiter #(.NUM_PORTS(N), .WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst), .req_din(req_din), .req_din_en(req_din_en),
    .req_din_eop(req_din_eop), .req_din_rdy(req_din_rdy), .blob_dout(blob_dout),
    .blob_dout_rdy(blob_dout_rdy), .blob_dout_en(blob_dout_en),
    .blob_dout_eop(blob_dout_eop), .grant_id(grant_id), .busy(busy), .trunc_err(trunc_err)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic put(input int p, input logic en, input logic eop, input logic [W-1:0] d);
    req_din_en[p] = en;
    req_din_eop[p] = eop;
    req_din[p*W +: W] = d;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    req_din_en = '0;
    req_din_eop = '0;
    blob_dout_rdy = 1;
    @(negedge clk);
    rst = 0;
  endtask
  task automatic beat(input string tag, input int p, input logic [W-1:0] d, input logic eop,
                      input logic exp_en, input logic exp_eop);
    @(negedge clk);
    put(p, 1, eop, d);
    #1;
    check({tag, ".en"}, blob_dout_en, exp_en);
    check({tag, ".eop"}, blob_dout_eop, exp_eop);
    if (exp_en) check({tag, ".dout"}, blob_dout, d);
  endtask
  initial begin
    do_reset();
    #1;
    check("rst.busy", busy, 0);
    check("rst.grant", grant_id, 0);
    check("rst.rdy", req_din_rdy, 0);
    check("rst.en", blob_dout_en, 0);
    check("rst.eop", blob_dout_eop, 0);
    check("rst.trunc", trunc_err, 0);
    check("rst.dout", blob_dout, 0);
    beat("t1.req", 2, 16'hA1, 0, 0, 0);
    check("t1.idle_rdy", req_din_rdy, 0);
    beat("t1.b1", 2, 16'hA1, 0, 1, 0);
    check("t1.grant", grant_id, 2);
    check("t1.busy", busy, 1);
    check("t1.rdy", req_din_rdy, 4'b0100);
    beat("t1.b2", 2, 16'hA2, 0, 1, 0);
    beat("t1.b3", 2, 16'hA3, 1, 1, 1);
    @(negedge clk);
    put(2, 0, 0, 0);
    #1;
    check("t1.done", busy, 0);
    do_reset();
    for (int p = 0; p < N; p++) begin bc[p] = 0; blk[p] = 0; end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      for (int p = 0; p < N; p++) put(p, 1, bc[p] == 1, W'(p*256 + blk[p]*16 + bc[p]));
      #1;
      ph = k % 3;
      b = k / 3;
      ep = b % 4;
      check("t2.en", blob_dout_en, ph != 0);
      check("t2.busy", busy, ph != 0);
      if (ph != 0) begin
        check("t2.grant", grant_id, ep);
        check("t2.dout", blob_dout, ep*256 + (b/4)*16 + ph - 1);
        check("t2.eop", blob_dout_eop, ph == 2);
      end
      for (int p = 0; p < N; p++)
        if (req_din_rdy[p] && req_din_en[p]) begin
          if (bc[p] == 1) begin bc[p] = 0; blk[p]++; end
          else bc[p]++;
        end
    end
    check("t2.blobs", blk[0] + blk[1] + blk[2] + blk[3], 5);
    check("t2.p0", blk[0], 2);
    do_reset();
    beat("t3.req", 1, 16'h300, 0, 0, 0);
    for (int i = 1; i <= 4; i++) beat("t3.b", 1, W'(16'h300 + i), 0, 1, i == 4);
    @(negedge clk);
    blob_dout_rdy = 0;
    put(1, 1, 0, 16'h305);
    #1;
    check("t3.d5_rdy", req_din_rdy, 4'b0010);
    check("t3.d5_en", blob_dout_en, 0);
    check("t3.d5_busy", busy, 1);
    check("t3.trunc", trunc_err, 4'b0010);
    @(negedge clk);
    put(1, 1, 1, 16'h306);
    #1;
    check("t3.d6_rdy", req_din_rdy, 4'b0010);
    check("t3.d6_en", blob_dout_en, 0);
    check("t3.d6_eop", blob_dout_eop, 0);
    @(negedge clk);
    put(1, 0, 0, 0);
    blob_dout_rdy = 1;
    #1;
    check("t3.idle", busy, 0);
    beat("t4.req", 0, 16'h400, 0, 0, 0);
    for (int i = 1; i <= 4; i++) beat("t4.b", 0, W'(16'h400 + i), i == 4, 1, i == 4);
    @(negedge clk);
    put(0, 0, 0, 0);
    #1;
    check("t4.idle", busy, 0);
    check("t4.trunc", trunc_err, 4'b0010);
    @(negedge clk);
    put(3, 1, 0, 16'h500);
    #1;
    check("t5.idle_rdy", req_din_rdy, 0);
    bt = 0;
    for (int k = 0; k < 20 && bt < 4; k++) begin
      @(negedge clk);
      r = (k % 2 == 0);
      blob_dout_rdy = r;
      put(3, 1, bt == 3, W'(16'h500 + bt));
      #1;
      check("t5.rdy", req_din_rdy, r ? 4'b1000 : 4'b0000);
      check("t5.en", blob_dout_en, r);
      if (r) begin
        check("t5.dout", blob_dout, 16'h500 + bt);
        check("t5.eop", blob_dout_eop, bt == 3);
        bt++;
      end
    end
    check("t5.beats", bt, 4);
    @(negedge clk);
    put(3, 0, 0, 0);
    blob_dout_rdy = 1;
    #1;
    check("t5.idle", busy, 0);
    check("t5.trunc", trunc_err, 4'b0010);
    beat("t6.req", 2, 16'h600, 0, 0, 0);
    beat("t6.b1", 2, 16'h601, 0, 1, 0);
    @(negedge clk);
    put(2, 1, 0, 16'h602);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    check("t6.busy", busy, 0);
    check("t6.grant", grant_id, 0);
    check("t6.trunc", trunc_err, 0);
    check("t6.en", blob_dout_en, 0);
    put(2, 0, 0, 0);
    put(3, 1, 1, 16'h6F0);
    @(negedge clk);
    #1;
    check("t6.grant3", grant_id, 3);
    check("t6.en3", blob_dout_en, 1);
    check("t6.dout3", blob_dout, 16'h6F0);
    check("t6.eop3", blob_dout_eop, 1);
    @(negedge clk);
    put(3, 0, 0, 0);
    #1;
    check("t6.idle", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
